// File: rtl/jtag_user_reg.sv
// jtag_user_reg: JTAG user data register bridged into the clk_i domain with a one-entry tx buffer
module jtag_user_reg #(
  parameter int WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             jtck_i,
  input  logic             jtdi_i,
  input  logic             jshift_i,
  input  logic             jupdate_i,
  input  logic             jrstn_i,
  input  logic             jce_i,
  output logic             jtdo_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_stb_o,
  input  logic [WIDTH-2:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o
);
  logic [5:0] meta_q, meta_d, sync_q, sync_d;
  logic tck_prev_q, tck_prev_d, upd_prev_q, upd_prev_d;
  logic [WIDTH-1:0] sr_q, sr_d, rx_q, rx_d;
  logic [WIDTH-2:0] buf_q, buf_d;
  logic full_q, full_d, tdo_q, tdo_d, stb_q, stb_d;
  logic tck, tdi, shift, upd, rstn, ce, rise, fall, upd_rise, cap, tx_wr;
  assign {ce, rstn, upd, shift, tdi, tck} = sync_q;
  always_comb begin
    meta_d = {jce_i, jrstn_i, jupdate_i, jshift_i, jtdi_i, jtck_i};
    sync_d = meta_q;
    tck_prev_d = tck;
    upd_prev_d = upd;
    rise = tck & ~tck_prev_q;
    fall = ~tck & tck_prev_q;
    upd_rise = upd & ~upd_prev_q & ce & rstn;
    cap = rise & ce & rstn & ~shift;
    tx_wr = tx_valid_i & ~full_q;
    sr_d = !rstn ? '0 : (rise & ce & shift) ? {tdi, sr_q[WIDTH-1:1]} : cap ? {full_q, buf_q} : sr_q;
    tdo_d = !rstn ? 1'b0 : fall ? sr_q[0] : tdo_q;
    rx_d = upd_rise ? sr_q : rx_q;
    stb_d = upd_rise;
    buf_d = tx_wr ? tx_data_i : buf_q;
    full_d = tx_wr | (full_q & ~cap);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      tck_prev_q <= 1'b0;
      upd_prev_q <= 1'b0;
      sr_q <= '0;
      rx_q <= '0;
      buf_q <= '0;
      full_q <= 1'b0;
      tdo_q <= 1'b0;
      stb_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      tck_prev_q <= tck_prev_d;
      upd_prev_q <= upd_prev_d;
      sr_q <= sr_d;
      rx_q <= rx_d;
      buf_q <= buf_d;
      full_q <= full_d;
      tdo_q <= tdo_d;
      stb_q <= stb_d;
    end
  end
  assign jtdo_o = tdo_q;
  assign rx_data_o = rx_q;
  assign rx_stb_o = stb_q;
  assign tx_ready_o = ~full_q;
endmodule
